regbank_bus_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares a bank of tri-state-output register flip-flops among several requesters.
- Each register has a ClockEnable/Tick write strobe and an active-high cs deselect; a deselected register's Q is high-Z.
- The block grants one requester at a time and issues that requester's write strobe or read select.
- It enforces a one-cycle bus turnaround so that no two registers ever drive the shared read bus in adjacent cycles.

---
 rtl/regbank_bus_arbiter.sv | 115 +++++++++++
 tb/tb_regbank_bus_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_bus_arbiter.sv
// regbank_bus_arbiter: round-robin sequencer sharing a tri-state register bank among requesters,
// with registered outputs and a mandatory turnaround cycle between read selects.
module regbank_bus_arbiter #(
    parameter int NrOfReq  = 4,
    parameter int NrOfRegs = 8,
    parameter int AddrBits = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NrOfReq-1:0]          req,
    input  logic [NrOfReq-1:0]          we,
    input  logic [NrOfReq*AddrBits-1:0] addr,
    output logic [NrOfReq-1:0]          gnt,
    output logic [2:0]                  gnt_idx,
    output logic [NrOfRegs-1:0]         reg_we,
    output logic [NrOfRegs-1:0]         reg_cs,
    output logic                        rd_valid,
    output logic                        done,
    output logic                        err
);
    localparam int IW = (NrOfReq > 1) ? $clog2(NrOfReq) : 1;

    typedef enum logic [2:0] {IDLE, GRANT, WRITE, RD_DRIVE, RD_SAMPLE, RELEASE} state_t;

    state_t                state, state_n;
    logic [2:0]            ptr, ptr_n, pick, idx_n;
    logic [3:0]            off, sum;
    logic [2*NrOfReq-1:0]  rot;
    logic [AddrBits-1:0]   addr_arr [NrOfReq];
    logic                  op_we, we_n, req_cur, bad_n;
    logic [AddrBits-1:0]   op_addr, addr_n;
    logic [NrOfReq-1:0]    gnt_d;
    logic [NrOfRegs-1:0]   sel_n, reg_we_d, reg_cs_d;
    logic                  rd_valid_d, done_d, err_d;

    // Rotate requests so the pointer sits at bit 0; the lowest set bit is the winner.
    always_comb begin
        rot = {req, req} >> ptr;
        off = '0;
        for (int k = NrOfReq - 1; k >= 0; k--)
            if (rot[k]) off = 4'(k);
        sum  = {1'b0, ptr} + off;
        pick = (sum >= 4'(NrOfReq)) ? 3'(sum - 4'(NrOfReq)) : sum[2:0];
        for (int i = 0; i < NrOfReq; i++)
            addr_arr[i] = addr[i*AddrBits +: AddrBits];
    end

    assign req_cur = req[gnt_idx[IW-1:0]];

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        idx_n   = gnt_idx;
        we_n    = op_we;
        addr_n  = op_addr;
        case (state)
            IDLE: if (|req) begin
                state_n = GRANT;
                idx_n   = pick;
                we_n    = we[pick[IW-1:0]];
                addr_n  = addr_arr[pick[IW-1:0]];
            end
            GRANT:     state_n = (err || !req_cur) ? RELEASE : (op_we ? WRITE : RD_DRIVE);
            WRITE:     state_n = RELEASE;
            RD_DRIVE:  state_n = req_cur ? RD_SAMPLE : RELEASE;
            RD_SAMPLE: state_n = RELEASE;
            RELEASE: begin
                state_n = IDLE;
                ptr_n   = (gnt_idx == 3'(NrOfReq - 1)) ? 3'd0 : gnt_idx + 3'd1;
            end
            default:   state_n = IDLE;
        endcase
    end

    // Outputs are computed for the state being entered, so every output leaves a flop.
    always_comb begin
        bad_n      = int'(addr_n) >= NrOfRegs;
        sel_n      = NrOfRegs'(1) << addr_n;
        gnt_d      = (state_n == GRANT || state_n == WRITE || state_n == RD_DRIVE || state_n == RD_SAMPLE)
                     ? NrOfReq'(1) << idx_n : '0;
        reg_we_d   = (state_n == WRITE) ? sel_n : '0;
        reg_cs_d   = (state_n == RD_DRIVE || state_n == RD_SAMPLE) ? ~sel_n : '1;
        rd_valid_d = state_n == RD_SAMPLE;
        err_d      = state_n == GRANT && bad_n;
        done_d     = state_n == WRITE || state_n == RD_SAMPLE || err_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            gnt_idx  <= '0;
            op_we    <= 1'b0;
            op_addr  <= '0;
            gnt      <= '0;
            reg_we   <= '0;
            reg_cs   <= '1;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            gnt_idx  <= idx_n;
            op_we    <= we_n;
            op_addr  <= addr_n;
            gnt      <= gnt_d;
            reg_we   <= reg_we_d;
            reg_cs   <= reg_cs_d;
            rd_valid <= rd_valid_d;
            done     <= done_d;
            err      <= err_d;
        end
    end
endmodule

// File: tb/tb_regbank_bus_arbiter.sv
// tb_regbank_bus_arbiter: directed and random stimulus against a transaction-level model
// of the arbiter; 4 requesters, 6 registers so that addresses 6 and 7 are out of range.
module tb_regbank_bus_arbiter;
    localparam logic [5:0] ONES = 6'h3F;
    localparam logic [5:0] BB [7] = '{6'h3D, 6'h3D, 6'h3F, 6'h3F, 6'h3F, 6'h2F, 6'h2F};

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [3:0]  req = '0, we = '0;
    logic [11:0] addr = '0;
    logic [3:0]  gnt;
    logic [2:0]  gnt_idx;
    logic [5:0]  reg_we, reg_cs, prev_cs = 6'h3F;
    logic        rd_valid, done, err;
    int          vectors = 0, fails = 0;

    always #5 clk = ~clk;

    regbank_bus_arbiter #(.NrOfReq(4), .NrOfRegs(6), .AddrBits(3)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
        .gnt(gnt), .gnt_idx(gnt_idx), .reg_we(reg_we), .reg_cs(reg_cs),
        .rd_valid(rd_valid), .done(done), .err(err)
    );

    // kind: 0 = write, 1 = read, 2 = bad address; k counts cycles since the grant (1 = grant cycle)
    typedef struct { bit busy; int owner; int kind; int k; int a; int ptr; int idx; } mstate_t;
    mstate_t m = '{0, 0, 0, 0, 0, 0, 0};

    function automatic int last_k(int kind);
        return kind == 2 ? 2 : (kind == 0 ? 3 : 4);
    endfunction

    function automatic mstate_t mstep(mstate_t s, logic [3:0] r, logic [3:0] w, logic [11:0] ad);
        mstate_t n = s;
        if (!s.busy) begin
            for (int j = 0; j < 4; j++) begin
                int c = (s.ptr + j) % 4;
                if (((r >> c) & 4'd1) != 0) begin
                    n.busy  = 1;
                    n.owner = c;
                    n.idx   = c;
                    n.a     = int'((ad >> (3 * c)) & 12'h7);
                    n.kind  = n.a >= 6 ? 2 : (((w >> c) & 4'd1) != 0 ? 0 : 1);
                    n.k     = 1;
                    break;
                end
            end
        end else if (s.k == last_k(s.kind)) begin
            n.busy = 0;
            n.ptr  = (s.owner + 1) % 4;
        end else if (((r >> s.owner) & 4'd1) == 0) begin
            n.k = last_k(s.kind);
        end else begin
            n.k = s.k + 1;
        end
        return n;
    endfunction

    function automatic logic [3:0] e_gnt(mstate_t s);
        return (s.busy && s.k < last_k(s.kind)) ? 4'(1 << s.owner) : 4'd0;
    endfunction
    function automatic logic [5:0] e_we(mstate_t s);
        return (s.busy && s.kind == 0 && s.k == 2) ? 6'(1 << s.a) : 6'd0;
    endfunction
    function automatic logic [5:0] e_cs(mstate_t s);
        return (s.busy && s.kind == 1 && (s.k == 2 || s.k == 3)) ? ~6'(1 << s.a) : ONES;
    endfunction
    function automatic logic e_rv(mstate_t s);
        return s.busy && s.kind == 1 && s.k == 3;
    endfunction
    function automatic logic e_err(mstate_t s);
        return s.busy && s.kind == 2 && s.k == 1;
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) m <= '{0, 0, 0, 0, 0, 0, 0};
        else        m <= mstep(m, req, we, addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m_gnt", 32'(gnt), 32'(e_gnt(m)));
        chk("m_gnt_idx", 32'(gnt_idx), 32'(m.idx));
        chk("m_reg_we", 32'(reg_we), 32'(e_we(m)));
        chk("m_reg_cs", 32'(reg_cs), 32'(e_cs(m)));
        chk("m_rd_valid", 32'(rd_valid), 32'(e_rv(m)));
        chk("m_err", 32'(err), 32'(e_err(m)));
        chk("m_done", 32'(done), 32'(e_err(m) || e_rv(m) || e_we(m) != 0));
        chk("inv_gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
        chk("inv_cs_onehot", 32'($countones(~reg_cs) <= 1), 32'd1);
        chk("inv_we_vs_cs", 32'(reg_we != 0 && reg_cs != ONES), 32'd0);
        if (prev_cs != ONES && reg_cs != ONES) chk("inv_turnaround", 32'(reg_cs), 32'(prev_cs));
        prev_cs <= reg_cs;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    initial begin
        int n, nb;
        int cyc_at [5];
        logic [5:0] wv [5];
        logic [5:0] seq [7];
        step();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_cs", 32'(reg_cs), 32'h3F);
        chk("rst_gnt_idx", 32'(gnt_idx), 0);
        do_reset();
        for (int c = 0; c < 10; c++) begin
            step();
            chk("idle_gnt", 32'(gnt), 0);
            chk("idle_cs", 32'(reg_cs), 32'h3F);
            chk("idle_we", 32'(reg_we), 0);
            chk("idle_done", 32'(done), 0);
        end
        req = 4'b0001; we = 4'b0001; addr = 12'd3;
        step(); chk("wr_gnt", 32'(gnt), 32'h1); chk("wr_gnt_we", 32'(reg_we), 0);
        step(); chk("wr_strobe", 32'(reg_we), 32'h08); chk("wr_done", 32'(done), 1);
        req = '0;
        step(); chk("wr_release", 32'(gnt), 0); chk("wr_done_off", 32'(done), 0);
        step();
        req = 4'b0100; we = '0; addr = 12'(5 << 6);
        step(); chk("rd_gnt", 32'(gnt), 32'h4); chk("rd_idx", 32'(gnt_idx), 2); chk("rd_cs_g", 32'(reg_cs), 32'h3F);
        step(); chk("rd_cs_drive", 32'(reg_cs), 32'h1F); chk("rd_valid_early", 32'(rd_valid), 0);
        step(); chk("rd_cs_sample", 32'(reg_cs), 32'h1F); chk("rd_valid", 32'(rd_valid), 1); chk("rd_done", 32'(done), 1);
        req = '0;
        step(); chk("rd_cs_release", 32'(reg_cs), 32'h3F); chk("rd_valid_off", 32'(rd_valid), 0);
        do_reset();
        req = 4'b1111; we = 4'b1111; addr = {3'd3, 3'd2, 3'd1, 3'd0};
        n = 0;
        for (int c = 0; c < 30 && n < 5; c++) begin
            step();
            if (reg_we != 0) begin
                wv[n] = reg_we;
                cyc_at[n] = c;
                n++;
            end
        end
        req = '0;
        chk("rr_count", n, 5);
        for (int i = 0; i < n; i++) chk("rr_order", 32'(wv[i]), 32'(1 << (i % 4)));
        for (int i = 1; i < n; i++) chk("rr_spacing", cyc_at[i] - cyc_at[i-1], 4);
        do_reset();
        req = 4'b0110; we = '0; addr = 12'h108;
        nb = 0;
        for (int c = 0; c < 30 && nb < 7; c++) begin
            step();
            if (nb > 0 || reg_cs != ONES) begin
                seq[nb] = reg_cs;
                nb++;
            end
            if (done && gnt[1]) req[1] = 1'b0;
            if (done && gnt[2]) req[2] = 1'b0;
        end
        req = '0;
        chk("b2b_count", nb, 7);
        for (int i = 0; i < nb; i++) chk("b2b_cs_seq", 32'(seq[i]), 32'(BB[i]));
        do_reset();
        req = 4'b0001; we = 4'b0001; addr = 12'd7;
        step(); chk("bad_err", 32'(err), 1); chk("bad_done", 32'(done), 1); chk("bad_we", 32'(reg_we), 0);
        step(); chk("bad_err_off", 32'(err), 0); chk("bad_gnt_off", 32'(gnt), 0);
        req = '0;
        repeat (2) step();
        do_reset();
        req = 4'b0001; we = '0; addr = 12'd2;
        step();
        step(); chk("ab_cs_drive", 32'(reg_cs), 32'h3B);
        req = '0;
        step(); chk("ab_cs_release", 32'(reg_cs), 32'h3F); chk("ab_no_done", 32'(done), 0); chk("ab_gnt", 32'(gnt), 0);
        req = 4'b0011; we = 4'b0011; addr = '0;
        step(); chk("ab_idle", 32'(gnt), 0);
        step(); chk("ab_ptr_adv", 32'(gnt), 32'h2); chk("ab_ptr_idx", 32'(gnt_idx), 1);
        req = '0;
        repeat (4) step();
        do_reset();
        req = 4'b0001; we = '0; addr = '0;
        step(); step(); step();
        chk("ar_cs_sample", 32'(reg_cs), 32'h3E); chk("ar_rv", 32'(rd_valid), 1);
        #1 rst_n = 1'b0;
        #1 chk("ar_cs_async", 32'(reg_cs), 32'h3F); chk("ar_rv_async", 32'(rd_valid), 0); chk("ar_gnt_async", 32'(gnt), 0);
        req = '0;
        step(); step();
        rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (c % 997 == 500) begin
                #1 rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
            for (int i = 0; i < 4; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[i] = 1'b1;
                        we[i] = 1'($urandom);
                        addr[i*3 +: 3] = 3'($urandom_range(0, 7));
                    end
                end else if (gnt[i] && done) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                    else begin
                        we[i] = 1'($urandom);
                        addr[i*3 +: 3] = 3'($urandom_range(0, 7));
                    end
                end else if ($urandom_range(0, 29) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
        req = '0;
        repeat (6) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
